// File: rtl/values_ram_arbiter.sv
// values_ram_arbiter: two-requester (CPU, debug/loader) arbiter for a
// single-port values RAM. Each access is a fixed four-cycle sequence:
// grant/latch, raise ram_clk, drop ram_clk and capture read data, then a
// one-cycle done pulse. The CPU has priority, but a pending debug request is
// served after STARVE_LIMIT consecutive CPU grants made while it waited.
// Every output is a flop.
module values_ram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  // debug/loader requester
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  // values RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_ew,
  output logic              ram_clk,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              owner_dbg, owner_dbg_nxt;   // 1: debug owns the current access
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              pick_dbg;

  logic              cpu_gnt_nxt, cpu_done_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt;
  logic              dbg_gnt_nxt, dbg_done_nxt;
  logic [DATA_W-1:0] dbg_rdata_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_nxt;
  logic              ram_ew_nxt, ram_clk_nxt;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + CNT_W'(1);
  endfunction

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt      = state;
    owner_dbg_nxt  = owner_dbg;
    starve_cnt_nxt = starve_cnt;
    pick_dbg       = 1'b0;
    cpu_gnt_nxt    = cpu_gnt;
    cpu_done_nxt   = cpu_done;
    cpu_rdata_nxt  = cpu_rdata;
    dbg_gnt_nxt    = dbg_gnt;
    dbg_done_nxt   = dbg_done;
    dbg_rdata_nxt  = dbg_rdata;
    ram_addr_nxt   = ram_addr;
    ram_data_nxt   = ram_data;
    ram_ew_nxt     = ram_ew;
    ram_clk_nxt    = ram_clk;

    case (state)
      IDLE: begin
        cpu_done_nxt = 1'b0;
        dbg_done_nxt = 1'b0;
        ram_clk_nxt  = 1'b0;
        ram_ew_nxt   = 1'b0;
        if (cpu_req || dbg_req) begin
          pick_dbg      = dbg_req && (!cpu_req || (starve_cnt == CNT_MAX));
          owner_dbg_nxt = pick_dbg;
          if (pick_dbg) begin
            ram_addr_nxt = dbg_addr;
            ram_data_nxt = dbg_wdata;
            ram_ew_nxt   = dbg_we;
            dbg_gnt_nxt  = 1'b1;
          end else begin
            ram_addr_nxt = cpu_addr;
            ram_data_nxt = cpu_wdata;
            ram_ew_nxt   = cpu_we;
            cpu_gnt_nxt  = 1'b1;
          end
          // Only a CPU grant that overtook a waiting debug request counts.
          if (pick_dbg || !dbg_req) starve_cnt_nxt = '0;
          else                      starve_cnt_nxt = sat_inc(starve_cnt);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        ram_clk_nxt = 1'b1;
        state_nxt   = STROBE;
      end
      STROBE: begin
        ram_clk_nxt = 1'b0;
        ram_ew_nxt  = 1'b0;
        // ram_ew still reflects the access type here: 0 means read.
        if (!ram_ew) begin
          if (owner_dbg) dbg_rdata_nxt = ram_q;
          else           cpu_rdata_nxt = ram_q;
        end
        state_nxt = DONE;
      end
      DONE: begin
        // Hand-off: gnt drops as done rises; done is cleared back in IDLE.
        if (owner_dbg) begin
          dbg_gnt_nxt  = 1'b0;
          dbg_done_nxt = 1'b1;
        end else begin
          cpu_gnt_nxt  = 1'b0;
          cpu_done_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, arbitration bookkeeping and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_dbg  <= 1'b0;
      starve_cnt <= '0;
      cpu_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      dbg_gnt    <= 1'b0;
      dbg_done   <= 1'b0;
      dbg_rdata  <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_ew     <= 1'b0;
      ram_clk    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_dbg  <= owner_dbg_nxt;
      starve_cnt <= starve_cnt_nxt;
      cpu_gnt    <= cpu_gnt_nxt;
      cpu_done   <= cpu_done_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      dbg_gnt    <= dbg_gnt_nxt;
      dbg_done   <= dbg_done_nxt;
      dbg_rdata  <= dbg_rdata_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_data   <= ram_data_nxt;
      ram_ew     <= ram_ew_nxt;
      ram_clk    <= ram_clk_nxt;
    end
  end

endmodule
